hazard_stall_controller: RTL

Pipeline sequencing controller for the 5-stage CPU. It watches Decode and Execute stage control/register fields and the data-memory busy flag, and drives the enable and flush (bubble) inputs of the PC, Fetch/Decode, Decode/Execute and Execute/Memory pipeline registers. It resolves three cases: load-use hazards (stall plus bubble), taken branches (flush of younger stages) and multi-cycle memory accesses (full freeze).

---
 rtl/hazard_stall_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush sequencer: load-use bubbles, taken-branch flushes and memory freezes.
// Optional HAZARD_STATS_EN adds saturating stall-cycle and branch-flush counters.
module hazard_stall_controller #(
  parameter int REG_ADDR_W          = 4,
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  rs1_used_d,
  input  logic                  rs2_used_d,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  wbs_e,
  input  logic                  mm_e,
  input  logic                  branch_taken_e,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  de_en,
  output logic                  em_en,
  output logic                  fd_flush,
  output logic                  de_flush,
`ifdef HAZARD_STATS_EN
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_events,
`endif
  output logic [1:0]            state_o
);

  // state      | meaning
  // RUN        | normal flow; events resolved with priority mem_busy > branch > hazard
  // LOAD_STALL | holding PC and F/D while bubbles enter D/E
  // MEM_WAIT   | full freeze until memory completes, plus one resume cycle
  // FLUSH      | continuing F/D and D/E flush after a taken branch
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  localparam logic [2:0] LS_INIT = (LOAD_STALL_CYCLES > 1)   ? 3'(LOAD_STALL_CYCLES - 2)   : 3'd0;
  localparam logic [2:0] BF_INIT = (BRANCH_FLUSH_CYCLES > 1) ? 3'(BRANCH_FLUSH_CYCLES - 2) : 3'd0;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       hazard;
  logic       branch_acc;

  assign hazard = mm_e & wbs_e & (rd_e != '0) &
                  ((rs1_used_d & (rs1_d == rd_e)) | (rs2_used_d & (rs2_d == rd_e)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    branch_acc = 1'b0;
    {pc_en, fd_en, de_en, em_en} = 4'b1111;
    {fd_flush, de_flush}         = 2'b00;
    unique case (state)
      RUN: begin
        if (mem_busy) begin
          {pc_en, fd_en, de_en, em_en} = 4'b0000;
          state_n = MEM_WAIT;
        end else if (branch_taken_e) begin
          {fd_flush, de_flush} = 2'b11;
          branch_acc = 1'b1;
          if (BRANCH_FLUSH_CYCLES > 1) begin
            state_n = FLUSH;
            cnt_n   = BF_INIT;
          end
        end else if (hazard) begin
          {pc_en, fd_en} = 2'b00;
          de_flush       = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_n = LOAD_STALL;
            cnt_n   = LS_INIT;
          end
        end
      end
      MEM_WAIT: begin
        // the cycle memory completes is still frozen; RUN re-evaluates afterwards
        {pc_en, fd_en, de_en, em_en} = 4'b0000;
        if (!mem_busy) state_n = RUN;
      end
      LOAD_STALL: begin
        if (mem_busy) begin
          {pc_en, fd_en, de_en, em_en} = 4'b0000;
        end else begin
          {pc_en, fd_en} = 2'b00;
          de_flush       = 1'b1;
          if (cnt == 3'd0) state_n = RUN;
          else             cnt_n   = cnt - 3'd1;
        end
      end
      FLUSH: begin
        if (mem_busy) begin
          {pc_en, fd_en, de_en, em_en} = 4'b0000;
        end else begin
          {fd_flush, de_flush} = 2'b11;
          if (cnt == 3'd0) state_n = RUN;
          else             cnt_n   = cnt - 3'd1;
        end
      end
      default: state_n = RUN;
    endcase
    if (rst) begin
      {pc_en, fd_en, de_en, em_en} = 4'b0000;
      {fd_flush, de_flush}         = 2'b11;
      branch_acc = 1'b0;
    end
  end

  assign state_o = rst ? 2'd0 : state;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      if (!pc_en && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (branch_acc && flush_events != 16'hFFFF) flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule
